// File: rtl/pixop_pkg.sv
// Shared mode codes and FSM state encoding for the pixel stream operator.
package pixop_pkg;

    localparam logic [1:0] PIXOP_ADD    = 2'd0;
    localparam logic [1:0] PIXOP_SUB    = 2'd1;
    localparam logic [1:0] PIXOP_THRESH = 2'd2;
    localparam logic [1:0] PIXOP_INVERT = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } pixop_state_e;

endpackage

// File: rtl/pixel_lane_op.sv
// Combinational single-pixel operator: saturating add/sub, threshold, invert.
module pixel_lane_op
    import pixop_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic [PIX_W-1:0] p,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] threshold,
    input  logic [PIX_W-1:0] value,
    output logic [PIX_W-1:0] result,
    output logic             sat
);

    localparam logic [PIX_W-1:0] PMAX = '1;

    logic        [PIX_W:0] sum;
    logic signed [PIX_W:0] diff;

    // One extra bit on both paths so clamping is decided before any wrap.
    always_comb begin
        sum    = {1'b0, p} + {1'b0, value};
        diff   = $signed({1'b0, p}) - $signed({1'b0, value});
        result = '0;
        sat    = 1'b0;
        case (mode)
            PIXOP_ADD: begin
                if (sum[PIX_W]) begin
                    result = PMAX;
                    sat    = 1'b1;
                end else begin
                    result = sum[PIX_W-1:0];
                end
            end
            PIXOP_SUB: begin
                if (diff < 0) begin
                    result = '0;
                    sat    = 1'b1;
                end else begin
                    result = diff[PIX_W-1:0];
                end
            end
            PIXOP_THRESH: result = (p >= threshold) ? PMAX : '0;
            default:      result = PMAX - p;
        endcase
    end

endmodule

// File: rtl/pixel_stream_operator.sv
// Two-stage valid/ready pixel operator with per-frame config latch and eof tagging.
// Optional saturation statistics enabled by defining PIXOP_SAT_STATS_EN.
module pixel_stream_operator
    import pixop_pkg::*;
#(
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned LANES     = 1,
    parameter int unsigned FRAME_PIX = 102400
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [1:0]                        cfg_mode,
    input  logic [PIX_W-1:0]                  cfg_threshold,
    input  logic [PIX_W-1:0]                  cfg_value,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*PIX_W-1:0]            in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*PIX_W-1:0]            out_data,
    output logic                              out_eof,
    output logic                              busy,
    output logic [$clog2(FRAME_PIX+1)-1:0]    frame_sat
);

    localparam int unsigned BEATS  = FRAME_PIX / LANES;
    localparam int unsigned CNT_W  = $clog2(BEATS + 1);
    localparam int unsigned SAT_W  = $clog2(FRAME_PIX + 1);
    localparam int unsigned DATA_W = LANES * PIX_W;

    pixop_state_e      state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              eof_tag, cfg_load;
    logic              accept, s1_move, s2_move;

    logic [1:0]        cfg_mode_q;
    logic [PIX_W-1:0]  cfg_thr_q, cfg_val_q;

    logic              s1_valid, s1_eof;
    logic [DATA_W-1:0] s1_data;
    logic [1:0]        s1_mode;
    logic [PIX_W-1:0]  s1_thr, s1_val;
    logic              s2_valid;

    logic [DATA_W-1:0] lane_res;
    logic [LANES-1:0]  lane_sat;

    // Stage 2 frees when empty or draining; stage 1 frees when empty or passing down.
    always_comb begin
        s2_move  = ~s2_valid | out_ready;
        s1_move  = ~s1_valid | s2_move;
        in_ready = s1_move;
        accept   = in_valid & s1_move;
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        eof_tag  = 1'b0;
        cfg_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cfg_load = 1'b1;
                    if (BEATS == 1) begin
                        eof_tag = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_ACTIVE;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    if (cnt == CNT_W'(BEATS - 1)) begin
                        eof_tag = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cfg_mode_q <= '0;
            cfg_thr_q  <= '0;
            cfg_val_q  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (cfg_load) begin
                cfg_mode_q <= cfg_mode;
                cfg_thr_q  <= cfg_threshold;
                cfg_val_q  <= cfg_value;
            end
        end
    end

    // Each beat carries its own config so back-to-back frames never mix modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_eof   <= 1'b0;
            s1_mode  <= '0;
            s1_thr   <= '0;
            s1_val   <= '0;
            s2_valid <= 1'b0;
            out_data <= '0;
            out_eof  <= 1'b0;
        end else begin
            if (s1_move) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_data <= in_data;
                    s1_eof  <= eof_tag;
                    s1_mode <= cfg_load ? cfg_mode      : cfg_mode_q;
                    s1_thr  <= cfg_load ? cfg_threshold : cfg_thr_q;
                    s1_val  <= cfg_load ? cfg_value     : cfg_val_q;
                end
            end
            if (s2_move) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= lane_res;
                    out_eof  <= s1_eof;
                end
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pixel_lane_op #(.PIX_W(PIX_W)) u_op (
            .p         (s1_data[i*PIX_W +: PIX_W]),
            .mode      (s1_mode),
            .threshold (s1_thr),
            .value     (s1_val),
            .result    (lane_res[i*PIX_W +: PIX_W]),
            .sat       (lane_sat[i])
        );
    end

    assign out_valid = s2_valid;
    assign busy      = (state == ST_ACTIVE);

`ifdef PIXOP_SAT_STATS_EN
    localparam int unsigned LCNT_W = $clog2(LANES + 1);

    logic [LCNT_W-1:0] beat_sat, s2_sat;
    logic [SAT_W-1:0]  sat_acc, frame_sat_q;

    always_comb begin
        beat_sat = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            beat_sat = beat_sat + LCNT_W'(lane_sat[i]);
        end
    end

    // Per-beat count rides in stage 2; frame total published with the eof beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sat      <= '0;
            sat_acc     <= '0;
            frame_sat_q <= '0;
        end else begin
            if (s2_move && s1_valid) begin
                s2_sat <= beat_sat;
            end
            if (s2_valid && out_ready) begin
                if (out_eof) begin
                    frame_sat_q <= sat_acc + SAT_W'(s2_sat);
                    sat_acc     <= '0;
                end else begin
                    sat_acc <= sat_acc + SAT_W'(s2_sat);
                end
            end
        end
    end

    assign frame_sat = frame_sat_q;
`else
    logic unused_sat;
    assign unused_sat = ^lane_sat;
    assign frame_sat  = '0;
`endif

endmodule

// File: tb/tb_pixel_stream_operator.sv
// Directed bench: 2 lanes, 8-pixel frames (4 beats), hand-computed expected beats.
module tb_pixel_stream_operator;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned LANES     = 2;
    localparam int unsigned FRAME_PIX = 8;
    localparam int unsigned SAT_W     = $clog2(FRAME_PIX + 1);
`ifdef PIXOP_SAT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [1:0]             cfg_mode;
    logic [PIX_W-1:0]       cfg_threshold;
    logic [PIX_W-1:0]       cfg_value;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*PIX_W-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*PIX_W-1:0] out_data;
    logic                   out_eof;
    logic                   busy;
    logic [SAT_W-1:0]       frame_sat;

    int n_checks = 0;
    int n_errors = 0;
    logic [16:0] got_q[$];

    always #5 clk = ~clk;

    pixel_stream_operator #(.PIX_W(PIX_W), .LANES(LANES), .FRAME_PIX(FRAME_PIX)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_mode      (cfg_mode),
        .cfg_threshold (cfg_threshold),
        .cfg_value     (cfg_value),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_eof       (out_eof),
        .busy          (busy),
        .frame_sat     (frame_sat)
    );

    // Output handshakes captured mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back({out_eof, out_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [15:0] d, input logic exp_busy);
        int w = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_accept"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    task automatic expect_frame(input string tag, input logic [15:0] r0, input logic [15:0] r1,
                                input logic [15:0] r2, input logic [15:0] r3, input int sat);
        logic [15:0] r[4];
        logic [16:0] g;
        int w = 0;
        r = '{r0, r1, r2, r3};
        while (got_q.size() < 4 && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_beats"}, 32'(got_q.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (got_q.size() == 0) break;
            g = got_q.pop_front();
            check($sformatf("%s_data%0d", tag, k), 32'(g[15:0]), 32'(r[k]));
            check($sformatf("%s_eof%0d", tag, k), 32'(g[16]), 32'(k == 3));
        end
        if (sat >= 0) check({tag, "_sat"}, 32'(frame_sat), STATS ? 32'(sat) : 32'd0);
    endtask

    initial begin
        logic [15:0] bp[4];
        int n;
        int guard;
        logic hs;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_mode = 2'd0; cfg_threshold = '0; cfg_value = '0;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_sat", 32'(frame_sat), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // ADD 60 with latency check on the first beat
        cfg_mode = 2'd0; cfg_value = 8'h3C;
        push("a1", 16'h10F0, 1'b1);
        push("a2", 16'hC300, 1'b1);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h4CFF);
        push("a3", 16'hC401, 1'b1);
        push("a4", 16'h0080, 1'b0);
        expect_frame("add", 16'h4CFF, 16'hFF3C, 16'hFF3D, 16'h3CBC, 2);

        // THRESH, INVERT, SUB frames back to back
        cfg_mode = 2'd2; cfg_threshold = 8'hA0;
        push("b1", 16'hA09F, 1'b1); push("b2", 16'h00FF, 1'b1);
        push("b3", 16'hA1A0, 1'b1); push("b4", 16'h0001, 1'b0);
        cfg_mode = 2'd3;
        push("c1", 16'h003C, 1'b1); push("c2", 16'hFF00, 1'b1);
        push("c3", 16'h5AA5, 1'b1); push("c4", 16'h1234, 1'b0);
        cfg_mode = 2'd1; cfg_value = 8'h3C;
        push("d1", 16'hFF3D, 1'b1); push("d2", 16'h3C20, 1'b1);
        push("d3", 16'h0000, 1'b1); push("d4", 16'h803C, 1'b0);
        expect_frame("thr", 16'hFF00, 16'h00FF, 16'hFFFF, 16'h0000, -1);
        expect_frame("inv", 16'hFFC3, 16'h00FF, 16'hA55A, 16'hEDCB, -1);
        expect_frame("sub", 16'hC301, 16'h0000, 16'h0000, 16'h4400, 3);

        // Backpressure: stalled output admits exactly two beats
        bp = '{16'hFF3D, 16'h3C20, 16'h0000, 16'h803C};
        out_ready = 1'b0; n = 0; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = bp[n];
            @(negedge clk);
            hs = in_ready;
            tick();
            if (hs) n++;
            if (c >= 2) check("bp_hold_data", 32'(out_data), 32'hC301);
        end
        check("bp_accepted", 32'(n), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1; guard = 0;
        while (n < 4 && guard < 20) begin
            in_data = bp[n];
            @(negedge clk);
            hs = in_ready;
            tick();
            if (hs) n++;
            guard++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 32'(n), 32'd4);
        expect_frame("bp", 16'hC301, 16'h0000, 16'h0000, 16'h4400, 3);

        // Mode change mid-frame takes effect only at the next frame
        cfg_mode = 2'd0; cfg_value = 8'h3C;
        push("e1", 16'h10F0, 1'b1); push("e2", 16'hC300, 1'b1);
        cfg_mode = 2'd3;
        push("e3", 16'hC401, 1'b1); push("e4", 16'h0080, 1'b0);
        push("f1", 16'h003C, 1'b1); push("f2", 16'hFF00, 1'b1);
        push("f3", 16'h5AA5, 1'b1); push("f4", 16'h1234, 1'b0);
        expect_frame("keep", 16'h4CFF, 16'hFF3C, 16'hFF3D, 16'h3CBC, -1);
        expect_frame("next", 16'hFFC3, 16'h00FF, 16'hA55A, 16'hEDCB, 0);

        // Reset mid-frame, then a full frame must end on its own 4th beat
        cfg_mode = 2'd0;
        push("g1", 16'h10F0, 1'b1); push("g2", 16'hC300, 1'b1); push("g3", 16'hC401, 1'b1);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_eof", 32'(out_eof), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        tick();
        rst_n = 1'b1;
        got_q.delete();
        tick();
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        cfg_mode = 2'd3;
        push("h1", 16'h003C, 1'b1); push("h2", 16'hFF00, 1'b1);
        push("h3", 16'h5AA5, 1'b1); push("h4", 16'h1234, 1'b0);
        expect_frame("post_rst", 16'hFFC3, 16'h00FF, 16'hA55A, 16'hEDCB, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
